// File: rtl/axis_input_stall_monitor_if.sv
// Bundles the per-channel starvation flags and the stall report of the input-side watchdog.
// The stream side is the master; the monitor is the slave.
interface axis_input_stall_monitor_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned CNT_W  = 16
);
    logic [NUM_CH-1:0] axis_empty_sigs;
    logic              inst_idle;
    logic              block;
    logic              block_sticky;
    logic [CH_W-1:0]   block_ch;
    logic [CNT_W-1:0]  stall_cycles;
    logic [7:0]        event_count;

    modport master (
        output axis_empty_sigs,
        output inst_idle,
        input  block,
        input  block_sticky,
        input  block_ch,
        input  stall_cycles,
        input  event_count
    );

    modport slave (
        input  axis_empty_sigs,
        input  inst_idle,
        output block,
        output block_sticky,
        output block_ch,
        output stall_cycles,
        output event_count
    );
endinterface

// File: rtl/axis_input_stall_monitor.sv
// Input-side stall watchdog: declares a block only after THRESH consecutive starved cycles,
// latches the first starving channel, measures stall length and counts stall events.
module axis_input_stall_monitor #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned THRESH = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    axis_input_stall_monitor_if.slave    mon
);
    typedef enum logic [1:0] {StIdle, StWatch, StBlocked} state_e;

    localparam logic [CNT_W-1:0] ThreshM1 = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] ThreshV  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e           state_q, state_d;
    logic             block_q, block_d;
    logic             sticky_q, sticky_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       evt_q, evt_d;

    logic             any_starve;
    logic [CH_W-1:0]  low_idx;
    logic [7:0]       evt_base;

    assign any_starve = (|mon.axis_empty_sigs) & ~mon.inst_idle;

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (mon.axis_empty_sigs[i]) begin
                low_idx = CH_W'(i);
            end
        end
    end

    // A clear on the same edge as a new event restarts the count from that event.
    assign evt_base = clear ? 8'd0 : evt_q;

    always_comb begin
        state_d  = state_q;
        block_d  = block_q;
        sticky_d = clear ? 1'b0 : sticky_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        evt_d    = evt_base;

        unique case (state_q)
            StIdle: begin
                block_d = 1'b0;
                cnt_d   = '0;
                if (any_starve) begin
                    state_d = StWatch;
                    cnt_d   = CNT_W'(1);
                    ch_d    = low_idx;
                end
            end
            StWatch: begin
                if (any_starve && cnt_q == ThreshM1) begin
                    state_d  = StBlocked;
                    cnt_d    = ThreshV;
                    block_d  = 1'b1;
                    sticky_d = 1'b1;
                    evt_d    = (evt_base == 8'hff) ? evt_base : evt_base + 8'd1;
                end else if (any_starve) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StBlocked: begin
                block_d = 1'b1;
                if (any_starve) begin
                    cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    state_d = StIdle;
                    block_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                block_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            block_q  <= 1'b0;
            sticky_q <= 1'b0;
            ch_q     <= '0;
            cnt_q    <= '0;
            evt_q    <= '0;
        end else begin
            state_q  <= state_d;
            block_q  <= block_d;
            sticky_q <= sticky_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            evt_q    <= evt_d;
        end
    end

    assign mon.block        = block_q;
    assign mon.block_sticky = sticky_q;
    assign mon.block_ch     = ch_q;
    assign mon.stall_cycles = cnt_q;
    assign mon.event_count  = evt_q;
endmodule

// File: tb/tb_axis_input_stall_monitor.sv
// Directed bench for the input stall watchdog; expected values are hand-derived per scenario.
module tb_axis_input_stall_monitor;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned THRESH = 16;
    localparam int unsigned CNT_W  = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    axis_input_stall_monitor_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    axis_input_stall_monitor #(
        .NUM_CH(NUM_CH),
        .CH_W  (CH_W),
        .THRESH(THRESH),
        .CNT_W (CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .mon  (bus.slave)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are read 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.axis_empty_sigs = 4'b0000;
        bus.inst_idle = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        n_total++;
        if (bus.block !== 1'b0) $display("FAIL rst_block: got %0d want 0", bus.block);
        else n_pass++;
        n_total++;
        if (bus.block_sticky !== 1'b0)
            $display("FAIL rst_sticky: got %0d want 0", bus.block_sticky);
        else n_pass++;
        n_total++;
        if (bus.block_ch !== 2'd0) $display("FAIL rst_ch: got %0d want 0", bus.block_ch);
        else n_pass++;
        n_total++;
        if (bus.stall_cycles !== 16'd0)
            $display("FAIL rst_cycles: got %0d want 0", bus.stall_cycles);
        else n_pass++;
        n_total++;
        if (bus.event_count !== 8'd0)
            $display("FAIL rst_events: got %0d want 0", bus.event_count);
        else n_pass++;
    endtask

    task automatic test_held();
        bus.axis_empty_sigs = 4'b0100;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            n_total++;
            if (bus.block !== 1'b0 || bus.stall_cycles !== 16'(c + 1))
                $display("FAIL held_pre cyc %0d: got block %0d cnt %0d want 0 %0d",
                         c + 1, bus.block, bus.stall_cycles, c + 1);
            else n_pass++;
        end
        tick(1);
        n_total++;
        if (bus.block !== 1'b1) $display("FAIL held_block: got %0d want 1", bus.block);
        else n_pass++;
        n_total++;
        if (bus.block_ch !== 2'd2) $display("FAIL held_ch: got %0d want 2", bus.block_ch);
        else n_pass++;
        n_total++;
        if (bus.stall_cycles !== 16'd16)
            $display("FAIL held_cycles: got %0d want 16", bus.stall_cycles);
        else n_pass++;
        n_total++;
        if (bus.event_count !== 8'd1 || bus.block_sticky !== 1'b1)
            $display("FAIL held_evt: got evt %0d sticky %0d want 1 1",
                     bus.event_count, bus.block_sticky);
        else n_pass++;
        bus.axis_empty_sigs = 4'b0000;
        tick(1);
        n_total++;
        if (bus.block !== 1'b0 || bus.stall_cycles !== 16'd0 || bus.block_ch !== 2'd2)
            $display("FAIL held_release: got block %0d cnt %0d ch %0d want 0 0 2",
                     bus.block, bus.stall_cycles, bus.block_ch);
        else n_pass++;
    endtask

    task automatic test_sub_threshold();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        n_total++;
        if (bus.event_count !== 8'd0 || bus.block_sticky !== 1'b0)
            $display("FAIL clear1: got evt %0d sticky %0d want 0 0",
                     bus.event_count, bus.block_sticky);
        else n_pass++;
        bus.axis_empty_sigs = 4'b0001;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            n_total++;
            if (bus.block !== 1'b0) $display("FAIL sub_block cyc %0d: got 1 want 0", c + 1);
            else n_pass++;
        end
        n_total++;
        if (bus.stall_cycles !== 16'd15)
            $display("FAIL sub_cycles: got %0d want 15", bus.stall_cycles);
        else n_pass++;
        bus.axis_empty_sigs = 4'b0000;
        tick(1);
        n_total++;
        if (bus.stall_cycles !== 16'd0 || bus.block !== 1'b0 || bus.event_count !== 8'd0
            || bus.block_ch !== 2'd0)
            $display("FAIL sub_end: got cnt %0d block %0d evt %0d ch %0d want 0 0 0 0",
                     bus.stall_cycles, bus.block, bus.event_count, bus.block_ch);
        else n_pass++;
    endtask

    task automatic test_two_channels();
        bus.axis_empty_sigs = 4'b1010;
        tick(1);
        n_total++;
        if (bus.block_ch !== 2'd1 || bus.stall_cycles !== 16'd1)
            $display("FAIL two_start: got ch %0d cnt %0d want 1 1",
                     bus.block_ch, bus.stall_cycles);
        else n_pass++;
        tick(5);
        bus.axis_empty_sigs = 4'b1000;
        tick(1);
        n_total++;
        if (bus.block_ch !== 2'd1 || bus.stall_cycles !== 16'd7)
            $display("FAIL two_switch: got ch %0d cnt %0d want 1 7",
                     bus.block_ch, bus.stall_cycles);
        else n_pass++;
        tick(9);
        n_total++;
        if (bus.block !== 1'b1 || bus.block_ch !== 2'd1 || bus.stall_cycles !== 16'd16
            || bus.event_count !== 8'd1)
            $display("FAIL two_block: got block %0d ch %0d cnt %0d evt %0d want 1 1 16 1",
                     bus.block, bus.block_ch, bus.stall_cycles, bus.event_count);
        else n_pass++;
        bus.axis_empty_sigs = 4'b0000;
        tick(1);
    endtask

    task automatic test_idle_mask();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        bus.axis_empty_sigs = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            bus.inst_idle = (c == 10);
            tick(1);
            n_total++;
            if (bus.block !== (c >= 26))
                $display("FAIL idle_block cyc %0d: got %0d want %0d", c + 1, bus.block, c >= 26);
            else n_pass++;
            if (c == 9 || c == 10 || c == 11) begin
                n_total++;
                if (bus.stall_cycles !== ((c == 9) ? 16'd10 : (c == 10) ? 16'd0 : 16'd1))
                    $display("FAIL idle_cnt cyc %0d: got %0d", c + 1, bus.stall_cycles);
                else n_pass++;
            end
        end
        bus.inst_idle = 1'b0;
        bus.axis_empty_sigs = 4'b0000;
        tick(1);
        n_total++;
        if (bus.event_count !== 8'd1) $display("FAIL idle_evt: got %0d want 1", bus.event_count);
        else n_pass++;
    endtask

    task automatic test_saturation();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        bus.axis_empty_sigs = 4'b0100;
        tick(70000);
        n_total++;
        if (bus.stall_cycles !== 16'hffff || bus.block !== 1'b1)
            $display("FAIL sat_cycles: got cnt %0d block %0d want 65535 1",
                     bus.stall_cycles, bus.block);
        else n_pass++;
        bus.axis_empty_sigs = 4'b0000;
        tick(1);
        n_total++;
        if (bus.block !== 1'b0 || bus.stall_cycles !== 16'd0)
            $display("FAIL sat_release: got block %0d cnt %0d want 0 0",
                     bus.block, bus.stall_cycles);
        else n_pass++;
        n_total++;
        if (bus.block_sticky !== 1'b1 || bus.event_count !== 8'd1)
            $display("FAIL sat_sticky: got sticky %0d evt %0d want 1 1",
                     bus.block_sticky, bus.event_count);
        else n_pass++;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        n_total++;
        if (bus.block_sticky !== 1'b0 || bus.event_count !== 8'd0 || bus.block_ch !== 2'd2)
            $display("FAIL sat_clear: got sticky %0d evt %0d ch %0d want 0 0 2",
                     bus.block_sticky, bus.event_count, bus.block_ch);
        else n_pass++;
    endtask

    task automatic test_clear_collision();
        bus.axis_empty_sigs = 4'b0001;
        tick(16);
        bus.axis_empty_sigs = 4'b0000;
        tick(1);
        n_total++;
        if (bus.event_count !== 8'd1) $display("FAIL coll_pre: got %0d want 1", bus.event_count);
        else n_pass++;
        bus.axis_empty_sigs = 4'b0010;
        tick(15);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        n_total++;
        if (bus.block !== 1'b1 || bus.block_sticky !== 1'b1 || bus.event_count !== 8'd1
            || bus.block_ch !== 2'd1)
            $display("FAIL coll_win: got block %0d sticky %0d evt %0d ch %0d want 1 1 1 1",
                     bus.block, bus.block_sticky, bus.event_count, bus.block_ch);
        else n_pass++;
        bus.axis_empty_sigs = 4'b0000;
        tick(1);
    endtask

    task automatic test_reset_mid_block();
        bus.axis_empty_sigs = 4'b1000;
        tick(20);
        n_total++;
        if (bus.block !== 1'b1 || bus.stall_cycles !== 16'd20)
            $display("FAIL rmb_pre: got block %0d cnt %0d want 1 20",
                     bus.block, bus.stall_cycles);
        else n_pass++;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_total++;
        if (bus.block !== 1'b0 || bus.block_sticky !== 1'b0 || bus.block_ch !== 2'd0
            || bus.stall_cycles !== 16'd0 || bus.event_count !== 8'd0)
            $display("FAIL rmb_zero: got %0d %0d %0d %0d %0d want 0 0 0 0 0", bus.block,
                     bus.block_sticky, bus.block_ch, bus.stall_cycles, bus.event_count);
        else n_pass++;
        tick(15);
        n_total++;
        if (bus.block !== 1'b0) $display("FAIL rmb_early: got %0d want 0", bus.block);
        else n_pass++;
        tick(1);
        n_total++;
        if (bus.block !== 1'b1 || bus.block_ch !== 2'd3 || bus.stall_cycles !== 16'd16)
            $display("FAIL rmb_again: got block %0d ch %0d cnt %0d want 1 3 16",
                     bus.block, bus.block_ch, bus.stall_cycles);
        else n_pass++;
        bus.axis_empty_sigs = 4'b0000;
        tick(1);
    endtask

    initial begin
        bus.axis_empty_sigs = 4'b0000;
        bus.inst_idle = 1'b0;
        test_reset();
        test_held();
        test_sub_threshold();
        test_two_channels();
        test_idle_mask();
        test_saturation();
        test_clear_collision();
        test_reset_mid_block();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axis_input_stall_monitor.md
Name: axis_input_stall_monitor

Overview:
- Watchdog for the input side of the PFB stream path.
- Watches per-channel AXIS starvation flags on the read_inputs loop: TVALID low while the consumer's TREADY is high.
- Reports a deadlock-style block only after starvation persists for a programmable number of consecutive cycles.
- Output-side backpressure monitors flag blocking immediately. This block filters transient input gaps, latches which channel starved, measures stall length and counts stall events for the sim deadlock reporter.

Parameters:
- NUM_CH, 4, number of input AXIS channels monitored.
- CH_W, 2, width of the channel index output; must satisfy 2^CH_W >= NUM_CH.
- THRESH, 16, consecutive starved cycles required to declare a block; legal range 2..2^CNT_W-1.
- CNT_W, 16, width of the stall cycle counter.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- clear, in, 1, synchronous clear of block_sticky and event_count only.
- axis_empty_sigs, in, NUM_CH, per-channel starvation flag (1 = starved this cycle).
- inst_idle, in, 1, monitored loop idle; masks all starvation.
- block, out, 1, stall currently declared.
- block_sticky, out, 1, set on any declared stall; held until clear or reset.
- block_ch, out, CH_W, lowest-index starving channel captured at start of the current/last episode.
- stall_cycles, out, CNT_W, live consecutive-starved-cycle count; saturates at 2^CNT_W-1.
- event_count, out, 8, number of IDLE/WATCH->BLOCKED transitions; saturates at 255.

Behaviour:
- any_starve = (|axis_empty_sigs) & ~inst_idle, combinational, sampled each rising edge.
- Reset: state IDLE; all outputs 0. A reset mid-episode returns everything to 0 on the next cycle.
- All outputs are registered. No combinational input-to-output path.
- State IDLE:
  - stall_cycles = 0, block = 0.
  - If any_starve: go to WATCH, stall_cycles <= 1, block_ch <= lowest set index of axis_empty_sigs.
- State WATCH:
  - If any_starve and stall_cycles == THRESH-1: go to BLOCKED, stall_cycles <= THRESH, block <= 1, block_sticky <= 1, event_count += 1 (saturating).
  - Else if any_starve: stall_cycles += 1.
  - Else: go to IDLE, stall_cycles <= 0.
- State BLOCKED:
  - block = 1.
  - If any_starve: stall_cycles += 1, saturating at 2^CNT_W-1.
  - Else: go to IDLE, block <= 0, stall_cycles <= 0.
- Latency:
  - Starvation first high in cycle 0 and held: block = 1 from cycle THRESH.
  - First non-starved cycle k: block = 0 from cycle k+1.
- block_ch:
  - Updated only on IDLE->WATCH. Held through WATCH/BLOCKED and after return to IDLE.
  - The starving channel changing mid-episode does not end the episode or update block_ch.
- Gaps: a single non-starved cycle (or inst_idle high) ends the episode, and counting restarts from 1.
- clear:
  - Zeroes block_sticky and event_count next cycle. Does not affect state, block, block_ch or stall_cycles.
  - If clear coincides with a WATCH->BLOCKED transition, the transition wins: block_sticky = 1, event_count = 1.
- Saturation: stall_cycles and event_count hold at maximum. No wrap.

Test Plan:
- Starvation held, THRESH=16: axis_empty_sigs=4'b0100 held from cycle 0 -> block=0 through cycle 15; block=1 at cycle 16; block_ch=2, stall_cycles=16, event_count=1, block_sticky=1.
- Sub-threshold starvation: 4'b0001 for 15 cycles, then 0 -> block never asserts; stall_cycles reaches 15, then reads 0; event_count=0.
- Two channels start together: 4'b1010 rising together -> block_ch=1. Later changing to 4'b1000 mid-episode keeps block_ch=1 and the count continuous.
- inst_idle masking: starvation held 40 cycles with inst_idle=1 on cycle 10 -> counter restarts; block rises at cycle 27, not 16.
- Saturation, release and clear, CNT_W=16: starvation held 70000 cycles -> stall_cycles holds 65535.
  - Release at cycle k -> block=0 at k+1.
  - Pulse clear -> block_sticky=0, event_count=0, block_ch unchanged.
  - clear asserted on the same edge as WATCH->BLOCKED -> block_sticky=1, event_count=1.
- Reset mid-BLOCKED: assert reset for one cycle during a stall -> next cycle all outputs 0. With starvation still held after reset releases, block reasserts THRESH cycles later.
